// File: rtl/smi_axis_input_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : smi_axis_input_adaptor
// Description : AXI Stream slave to SMI frame adaptor. Uses an output register
//               plus a one-entry skid register. Optional sticky keep checking
//               is enabled by SMI_AXIS_IN_PROTOCOL_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module smi_axis_input_adaptor #(
    parameter int DataIndexSize = 3,
    parameter int UserWidth     = 1,
    parameter int DataWidth     = (1 << DataIndexSize) * 8,
    parameter int KeepWidth     = (1 << DataIndexSize)
) (
    input  logic                 clk,
    input  logic                 srstn,
    input  logic                 axisInValid,
    input  logic [DataWidth-1:0] axisInData,
    input  logic [KeepWidth-1:0] axisInKeep,
    input  logic [UserWidth-1:0] axisInUser,
    input  logic                 axisInLast,
    output logic                 axisInReady,
    output logic                 smiOutValid,
    output logic [DataWidth-1:0] smiOutData,
    output logic [7:0]           smiOutEofc,
    output logic [UserWidth-1:0] smiOutUser,
    input  logic                 smiOutStop,
    output logic                 frameActive,
    output logic [2:0]           protocolError
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } frameState_t;

    frameState_t            r_state;
    frameState_t            w_stateNext;

    logic                   r_inReady;
    logic                   r_outValid;
    logic [DataWidth-1:0]   r_outData;
    logic [7:0]             r_outEofc;
    logic [UserWidth-1:0]   r_outUser;
    logic                   r_skidValid;
    logic [DataWidth-1:0]   r_skidData;
    logic [7:0]             r_skidEofc;
    logic [UserWidth-1:0]   r_skidUser;

    logic                   w_accept;
    logic                   w_consume;
    logic                   w_skidValidNext;
    logic [7:0]             w_eofc;

    assign w_accept  = axisInValid && r_inReady;
    assign w_consume = r_outValid && !smiOutStop;

    // Skid holds a beat only when the output register is occupied and stalled.
    assign w_skidValidNext = r_skidValid ? !w_consume
                                         : (w_accept && r_outValid && !w_consume);

    // Last beat: highest set keep bit + 1; an empty keep still counts as one byte.
    always_comb begin
        w_eofc = 8'h00;
        if (axisInLast) begin
            w_eofc = 8'h01;
            for (int i = 0; i < KeepWidth; i++) begin
                if (axisInKeep[i]) begin
                    w_eofc = 8'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_inReady   <= 1'b0;
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_outEofc   <= '0;
            r_outUser   <= '0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
            r_skidEofc  <= '0;
            r_skidUser  <= '0;
        end else begin
            if (r_skidValid) begin
                if (w_consume) begin
                    r_outData   <= r_skidData;
                    r_outEofc   <= r_skidEofc;
                    r_outUser   <= r_skidUser;
                    r_skidValid <= 1'b0;
                end
            end else if (w_accept) begin
                if (!r_outValid || w_consume) begin
                    r_outValid <= 1'b1;
                    r_outData  <= axisInData;
                    r_outEofc  <= w_eofc;
                    r_outUser  <= axisInUser;
                end else begin
                    r_skidValid <= 1'b1;
                    r_skidData  <= axisInData;
                    r_skidEofc  <= w_eofc;
                    r_skidUser  <= axisInUser;
                end
            end else if (w_consume) begin
                r_outValid <= 1'b0;
            end
            r_inReady <= !w_skidValidNext;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (w_accept) begin
            w_stateNext = axisInLast ? IDLE : FRAME;
        end
    end

    assign axisInReady = r_inReady;
    assign smiOutValid = r_outValid;
    assign smiOutData  = r_outData;
    assign smiOutEofc  = r_outEofc;
    assign smiOutUser  = r_outUser;
    assign frameActive = (r_state == FRAME);

`ifdef SMI_AXIS_IN_PROTOCOL_CHECK_EN
    logic [2:0]           r_protocolError;
    logic [KeepWidth-1:0] w_keepPlusOne;
    logic                 w_keepContig;

    // keep of the form 0..01..1 has no bit shared with keep+1.
    assign w_keepPlusOne = axisInKeep + 1'b1;
    assign w_keepContig  = ((axisInKeep & w_keepPlusOne) == '0);

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_protocolError <= 3'b000;
        end else if (w_accept) begin
            if (axisInLast && !w_keepContig) begin
                r_protocolError[0] <= 1'b1;
            end
            if (!axisInLast && (axisInKeep != '1)) begin
                r_protocolError[1] <= 1'b1;
            end
            if (axisInLast && (axisInKeep == '0)) begin
                r_protocolError[2] <= 1'b1;
            end
        end
    end

    assign protocolError = r_protocolError;
`else
    assign protocolError = 3'b000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_smi_axis_input_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_smi_axis_input_adaptor
// Description : Scoreboard bench for smi_axis_input_adaptor (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smi_axis_input_adaptor;

`ifdef SMI_AXIS_IN_PROTOCOL_CHECK_EN
    localparam logic [2:0] c_expZero = 3'b100;
    localparam logic [2:0] c_expBoth = 3'b101;
`else
    localparam logic [2:0] c_expZero = 3'b000;
    localparam logic [2:0] c_expBoth = 3'b000;
`endif

    logic        clk;
    logic        srstn;
    logic        axisInValid;
    logic [63:0] axisInData;
    logic [7:0]  axisInKeep;
    logic [0:0]  axisInUser;
    logic        axisInLast;
    logic        axisInReady;
    logic        smiOutValid;
    logic [63:0] smiOutData;
    logic [7:0]  smiOutEofc;
    logic [0:0]  smiOutUser;
    logic        smiOutStop;
    logic        frameActive;
    logic [2:0]  protocolError;

    int nChecks = 0;
    int nPass   = 0;
    logic [72:0] expQ[$];

    smi_axis_input_adaptor #(
        .DataIndexSize(3),
        .UserWidth    (1)
    ) dut (
        .clk          (clk),
        .srstn        (srstn),
        .axisInValid  (axisInValid),
        .axisInData   (axisInData),
        .axisInKeep   (axisInKeep),
        .axisInUser   (axisInUser),
        .axisInLast   (axisInLast),
        .axisInReady  (axisInReady),
        .smiOutValid  (smiOutValid),
        .smiOutData   (smiOutData),
        .smiOutEofc   (smiOutEofc),
        .smiOutUser   (smiOutUser),
        .smiOutStop   (smiOutStop),
        .frameActive  (frameActive),
        .protocolError(protocolError)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Present a beat, record its expected output, return 1ns after acceptance.
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic u,
                        input logic l, input logic [7:0] e);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        axisInValid = 1'b1;
        axisInData  = d;
        axisInKeep  = k;
        axisInUser  = u;
        axisInLast  = l;
        expQ.push_back({d, e, u});
        while (!done) begin
            @(negedge clk);
            if (axisInReady) begin
                @(posedge clk);
                #1;
                done = 1;
            end else if (++n > 50) begin
                chk("acceptTimeout", 80'd0, 80'd1);
                done = 1;
            end
        end
    endtask

    // Monitor: pops on each consumed beat, and checks hold stability under stop.
    logic        heldV = 1'b0;
    logic [72:0] heldBeat;
    always @(negedge clk) begin
        if (!srstn) begin
            heldV = 1'b0;
        end else begin
            if (heldV) chk("holdStable", {smiOutValid, smiOutData, smiOutEofc, smiOutUser},
                           {1'b1, heldBeat});
            if (smiOutValid && !smiOutStop) begin
                if (expQ.size() == 0) chk("unexpectedBeat", {smiOutData, smiOutEofc, smiOutUser}, 80'd0);
                else chk("beat", {smiOutData, smiOutEofc, smiOutUser}, expQ.pop_front());
            end
            heldV    = smiOutValid && smiOutStop;
            heldBeat = {smiOutData, smiOutEofc, smiOutUser};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srstn       = 1'b0;
        axisInValid = 1'b0;
        axisInData  = '0;
        axisInKeep  = '0;
        axisInUser  = '0;
        axisInLast  = 1'b0;
        smiOutStop  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rstValid", smiOutValid, 0);
        chk("rstReady", axisInReady, 0);
        chk("rstFrame", frameActive, 0);
        chk("rstErr", protocolError, 0);
        chk("rstOut", {smiOutData, smiOutEofc, smiOutUser}, 0);
        srstn = 1'b1;
        #1 chk("readyBeforeEdge", axisInReady, 0);
        @(posedge clk);
        #1 chk("readyFirstEdge", axisInReady, 1);

        // 3-beat frame FF/FF/07, 1-cycle latency, consecutive eofc
        send(64'h0101_0101_0101_0101, 8'hFF, 1'b0, 1'b0, 8'h00);
        chk("f3b1", {smiOutValid, smiOutEofc, frameActive}, {1'b1, 8'h00, 1'b1});
        send(64'h0202_0202_0202_0202, 8'hFF, 1'b1, 1'b0, 8'h00);
        chk("f3b2", {smiOutValid, smiOutEofc, frameActive}, {1'b1, 8'h00, 1'b1});
        send(64'h0303_0303_0303_0303, 8'h07, 1'b0, 1'b1, 8'h03);
        chk("f3b3", {smiOutValid, smiOutEofc, frameActive}, {1'b1, 8'h03, 1'b0});
        axisInValid = 1'b0;
        @(posedge clk);
        #1 chk("f3Drained", smiOutValid, 0);

        // Single-beat frame
        send(64'hDEAD_BEEF_0000_1111, 8'hFF, 1'b1, 1'b1, 8'h08);
        chk("singleEofc", {smiOutValid, smiOutEofc, frameActive}, {1'b1, 8'h08, 1'b0});
        axisInValid = 1'b0;
        @(posedge clk);
        #1 chk("singleFrameIdle", frameActive, 0);

        // Continuous input with a 4-cycle stop window
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(64'hA0 + 64'(i), 8'hFF, 1'(i), (i == 7), (i == 7) ? 8'h08 : 8'h00);
                axisInValid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 smiOutStop = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                chk("stopReady", axisInReady, 0);
                chk("stopHeld", {smiOutValid, smiOutData, frameActive}, {1'b1, 64'hA2, 1'b1});
                smiOutStop = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1 chk("stopAllOut", expQ.size(), 0);

        // Empty keep on last beat
        send(64'h5555_0000_5555_0000, 8'h00, 1'b0, 1'b1, 8'h01);
        chk("keepZeroEofc", smiOutEofc, 8'h01);
        chk("keepZeroErr", protocolError, c_expZero);
        send(64'h6666_0000_6666_0000, 8'hFF, 1'b0, 1'b1, 8'h08);
        chk("errSticky", protocolError, c_expZero);

        // Non-contiguous keep on last beat
        send(64'h7777_0000_7777_0000, 8'h05, 1'b1, 1'b1, 8'h03);
        chk("keep05Eofc", smiOutEofc, 8'h03);
        chk("keep05Err", protocolError, c_expBoth);
        axisInValid = 1'b0;

        // Reset mid-frame with stop asserted
        send(64'h8888_0000_0000_0001, 8'hFF, 1'b0, 1'b0, 8'h00);
        chk("midFrameActive", frameActive, 1);
        smiOutStop = 1'b1;
        send(64'h8888_0000_0000_0002, 8'hFF, 1'b0, 1'b0, 8'h00);
        axisInValid = 1'b0;
        #2 srstn = 1'b0;
        #1;
        chk("rstMidValid", smiOutValid, 0);
        chk("rstMidFrame", frameActive, 0);
        chk("rstMidReady", axisInReady, 0);
        chk("rstMidErr", protocolError, 0);
        chk("rstMidOut", {smiOutData, smiOutEofc, smiOutUser}, 0);
        expQ.delete();
        smiOutStop = 1'b0;
        repeat (2) @(posedge clk);
        #3 srstn = 1'b1;
        @(posedge clk);
        #1 chk("rstRelReady", {axisInReady, smiOutValid}, {1'b1, 1'b0});
        repeat (3) @(posedge clk);
        #1 chk("noStaleBeat", smiOutValid, 0);
        send(64'h9999_0000_0000_0001, 8'hFF, 1'b0, 1'b0, 8'h00);
        chk("newFrameActive", frameActive, 1);
        send(64'h9999_0000_0000_0002, 8'h0F, 1'b1, 1'b1, 8'h04);
        chk("newFrameEnd", {smiOutEofc, frameActive}, {8'h04, 1'b0});
        axisInValid = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("finalDrain", expQ.size(), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smi_axis_input_adaptor.md
SMI_AXIS_INPUT_ADAPTOR -- requirements
Module: smi_axis_input_adaptor

Interface
REQ-001 The block SHALL have parameter DataIndexSize, default 3, giving log2 of bytes per beat.
REQ-002 The block SHALL have parameter UserWidth, default 1, giving the width of the AXI user signal; when user is unused, width is 1 and the input is tied low.
REQ-003 The block SHALL have parameter DataWidth, default (1<<DataIndexSize)*8, derived and not overridden.
REQ-004 The block SHALL have parameter KeepWidth, default (1<<DataIndexSize), derived and not overridden.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port srstn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 The block SHALL have ports axisInValid (input, 1), axisInData (input, DataWidth), axisInKeep (input, KeepWidth), axisInUser (input, UserWidth) and axisInLast (input, 1): the AXI Stream slave beat.
REQ-008 The block SHALL have port axisInReady, output, 1 bit, driven only from a register.
REQ-009 The block SHALL have ports smiOutValid (output, 1), smiOutData (output, DataWidth), smiOutEofc (output, 8) and smiOutUser (output, UserWidth): the SMI frame beat.
REQ-010 The block SHALL have port smiOutStop, input, 1 bit: SMI backpressure.
REQ-011 The block SHALL have port frameActive, output, 1 bit: high while a frame is partially transferred on the input.
REQ-012 The block SHALL have port protocolError, output, 3 bits: sticky error flags (see Configuration).

Function
REQ-013 An input beat SHALL be accepted on a rising edge where axisInValid and axisInReady are both 1; an output beat SHALL be consumed where smiOutValid is 1 and smiOutStop is 0.
REQ-014 The datapath SHALL be an output register plus a one-entry skid register; first-beat latency SHALL be exactly 1 cycle from acceptance to smiOutValid.
REQ-015 axisInReady SHALL be 1 whenever the skid register is empty; it SHALL fall on the cycle after a beat lands in the skid register, and SHALL rise on the cycle after the skid register drains.
REQ-016 Sustained throughput SHALL be 1 beat per cycle while smiOutStop is 0; no beat SHALL be lost or duplicated across any stop toggle pattern.
REQ-017 Output SHALL be held stable (valid, data, eofc, user) while smiOutValid is 1 and smiOutStop is 1.
REQ-018 EOFC mapping, when axisInLast is 0: smiOutEofc SHALL be 8'h00, with keep ignored for data.
REQ-019 EOFC mapping, when axisInLast is 1: smiOutEofc SHALL be the index of the highest set keep bit plus 1 (range 1..KeepWidth).
REQ-020 EOFC mapping, when axisInLast is 1 and keep is all zero: smiOutEofc SHALL be 8'h01.
REQ-021 Data and user SHALL pass unmodified; byte lanes above EOFC are not cleared.
REQ-022 The frame FSM SHALL have states IDLE and FRAME.
REQ-023 The frame FSM SHALL transition IDLE->FRAME on an accepted beat with last=0.
REQ-024 The frame FSM SHALL transition FRAME->IDLE on an accepted beat with last=1; a single-beat frame in IDLE SHALL stay in IDLE.
REQ-025 frameActive SHALL equal (state==FRAME).
REQ-026 Simultaneous input accept and output consume with the skid register empty SHALL pass the new beat directly into the output register.

Reset
REQ-027 When srstn is low, the block SHALL immediately force smiOutValid=0, axisInReady=0, the skid register empty, state=IDLE, frameActive=0 and protocolError=0.
REQ-028 When srstn is low, data, eofc and user SHALL be cleared to 0.
REQ-029 After srstn rises, axisInReady SHALL go to 1 on the first clock edge.
REQ-030 A reset mid-frame SHALL discard the held beats; the next accepted beat SHALL begin a new frame.

Configuration
REQ-031 With SMI_AXIS_IN_PROTOCOL_CHECK_EN defined, on each accepted beat the block SHALL set protocolError[0] when last=1 and keep is non-contiguous from bit 0, protocolError[1] when last=0 and keep is not all ones, and protocolError[2] when last=1 and keep is zero.
REQ-032 With SMI_AXIS_IN_PROTOCOL_CHECK_EN defined, the error bits SHALL clear only on reset and SHALL never alter the datapath.
REQ-033 Without SMI_AXIS_IN_PROTOCOL_CHECK_EN, protocolError SHALL be constant 3'b000 and the checking logic SHALL be absent.

Verification
REQ-034 With DataIndexSize=3, a 3-beat frame with keep FF/FF/07, last on beat 3 and stop=0 SHALL produce eofc 00,00,03 on consecutive cycles with 1-cycle latency.
REQ-035 A single beat with keep=FF and last=1 SHALL produce eofc=08, with frameActive remaining 0 throughout.
REQ-036 A continuous input with stop high for 4 cycles mid-frame SHALL cause axisInReady to fall after 2 beats are held and the output to be held stable; after stop is released, all beats SHALL arrive in order with none dropped.
REQ-037 A last beat with keep=00 SHALL produce eofc=01; with the macro defined, protocolError SHALL become 3'b100 and stay so.
REQ-038 A last beat with keep=05 under the macro SHALL produce eofc=03 and protocolError[0]=1.
REQ-039 Asserting srstn low mid-frame while stop=1 SHALL immediately drive smiOutValid=0 and frameActive=0, and SHALL leave no stale beat after release.
